// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared constants for the ULA/bus datapath core
package ula_pkg;

    localparam int N_DEF = 16;

    localparam logic [2:0] ULA_ADD = 3'b000;
    localparam logic [2:0] ULA_SUB = 3'b001;
    localparam logic [2:0] ULA_OR  = 3'b010;
    localparam logic [2:0] ULA_SLT = 3'b011;
    localparam logic [2:0] ULA_SLL = 3'b100;
    localparam logic [2:0] ULA_SRL = 3'b101;

    // Bus sources packed into one select vector; lower index wins on conflict.
    localparam int NUM_REGS = 8;
    localparam int SEL_DIN  = 0;
    localparam int SEL_R0   = 1;
    localparam int SEL_G    = SEL_R0 + NUM_REGS;
    localparam int SEL_W    = SEL_G + 1;

    typedef logic [SEL_W-1:0] bus_sel_t;

endpackage

// File: rtl/dec3to8_unit.sv
// rtl/dec3to8_unit.sv - 3-to-8 one-hot decoder with enable
module dec3to8_unit (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'b0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ula_bus_unit.sv
// rtl/ula_bus_unit.sv - bus mux, field decoders, ULA and G register (optional flags: ULA_FLAGS_EN)
module ula_bus_unit
    import ula_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [N-1:0]      DIN,
    input  logic [8*N-1:0]    Rflat,
    input  logic [N-1:0]      A,
    input  logic              dinOut,
    input  logic [7:0]        regOut,
    input  logic              gOut,
    input  logic [2:0]        sinal_ULA,
    input  logic              gIn,
    input  logic [2:0]        IRx,
    input  logic [2:0]        IRy,
    input  logic              decEn,
    output logic [N-1:0]      BusWires,
    output logic [N-1:0]      G,
    output logic [7:0]        Xreg,
    output logic [7:0]        Yreg
`ifdef ULA_FLAGS_EN
    ,
    output logic              Z,
    output logic              C
`endif
);

    bus_sel_t     bus_sel;
    logic [N-1:0] bus_src [SEL_W];
    logic [N-1:0] ula_result;

    dec3to8_unit u_dec_x (
        .idx    (IRx),
        .en     (decEn),
        .onehot (Xreg)
    );

    dec3to8_unit u_dec_y (
        .idx    (IRy),
        .en     (decEn),
        .onehot (Yreg)
    );

    assign bus_sel = {gOut, regOut, dinOut};

    always_comb begin
        bus_src[SEL_DIN] = DIN;
        for (int k = 0; k < NUM_REGS; k++) begin
            bus_src[SEL_R0 + k] = Rflat[k*N +: N];
        end
        bus_src[SEL_G] = G;
    end

    // Scan from lowest priority up so the last hit is the winning source.
    always_comb begin
        BusWires = '0;
        for (int i = SEL_W - 1; i >= 0; i--) begin
            if (bus_sel[i]) begin
                BusWires = bus_src[i];
            end
        end
    end

    always_comb begin
        ula_result = '0;
        case (sinal_ULA)
            ULA_ADD: ula_result = A + BusWires;
            ULA_SUB: ula_result = A - BusWires;
            ULA_OR:  ula_result = A | BusWires;
            ULA_SLT: ula_result = {{(N-1){1'b0}}, ($signed(A) < $signed(BusWires))};
            ULA_SLL: ula_result = A << BusWires[3:0];
            ULA_SRL: ula_result = A >> BusWires[3:0];
            default: ula_result = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            G <= '0;
        end else if (gIn) begin
            G <= ula_result;
        end
    end

`ifdef ULA_FLAGS_EN
    logic [N:0] add_ext;
    logic       carry_next;

    assign add_ext = {1'b0, A} + {1'b0, BusWires};

    always_comb begin
        carry_next = 1'b0;
        case (sinal_ULA)
            ULA_ADD: carry_next = add_ext[N];
            ULA_SUB: carry_next = (A < BusWires);
            default: carry_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Resetn) begin
            Z <= 1'b0;
            C <= 1'b0;
        end else if (gIn) begin
            Z <= (ula_result == '0);
            C <= carry_next;
        end
    end
`endif

endmodule

// File: tb/tb_ula_bus_unit.sv
// tb/tb_ula_bus_unit.sv - directed scoreboard bench for ula_bus_unit
module tb_ula_bus_unit;

    localparam int W = 16;

    logic           Clock = 1'b0;
    logic           Resetn;
    logic [W-1:0]   DIN;
    logic [8*W-1:0] Rflat;
    logic [W-1:0]   A;
    logic           dinOut;
    logic [7:0]     regOut;
    logic           gOut;
    logic [2:0]     sinal_ULA;
    logic           gIn;
    logic [2:0]     IRx;
    logic [2:0]     IRy;
    logic           decEn;
    logic [W-1:0]   BusWires;
    logic [W-1:0]   G;
    logic [7:0]     Xreg;
    logic [7:0]     Yreg;
`ifdef ULA_FLAGS_EN
    logic           Z;
    logic           C;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] sb [$];

    ula_bus_unit #(.N(W)) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .DIN       (DIN),
        .Rflat     (Rflat),
        .A         (A),
        .dinOut    (dinOut),
        .regOut    (regOut),
        .gOut      (gOut),
        .sinal_ULA (sinal_ULA),
        .gIn       (gIn),
        .IRx       (IRx),
        .IRy       (IRy),
        .decEn     (decEn),
        .BusWires  (BusWires),
        .G         (G),
        .Xreg      (Xreg),
        .Yreg      (Yreg)
`ifdef ULA_FLAGS_EN
        ,
        .Z         (Z),
        .C         (C)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_g(input string tag);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            check(tag, G, sb.pop_front());
        end
    endtask

    // Drives one ULA operation with the operand B taken from DIN and checks G after the edge.
    task automatic g_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic [W-1:0] exp);
        @(negedge Clock);
        A = a; DIN = b; dinOut = 1'b1; regOut = 8'h00; gOut = 1'b0;
        sinal_ULA = op; gIn = 1'b1;
        sb.push_back(exp);
        @(posedge Clock);
        #1;
        gIn = 1'b0;
        check_g(tag);
    endtask

    initial begin
        Resetn = 1'b1; DIN = '0; Rflat = '0; A = '0; dinOut = 1'b0; regOut = 8'h00;
        gOut = 1'b0; sinal_ULA = 3'b000; gIn = 1'b1; IRx = 3'd0; IRy = 3'd0; decEn = 1'b0;
        for (int k = 0; k < 8; k++) Rflat[k*W +: W] = 16'h1000 + 16'(k);
        Rflat[3*W +: W] = 16'h1234;

        repeat (2) @(posedge Clock);
        #1;
        check("reset_g", G, 16'h0000);
        check("idle_bus", BusWires, 16'h0000);
        @(negedge Clock);
        Resetn = 1'b0; gIn = 1'b0;

        IRx = 3'd5; IRy = 3'd0; decEn = 1'b1;
        #1;
        check("dec_x5", {8'h00, Xreg}, 16'h0020);
        check("dec_y0", {8'h00, Yreg}, 16'h0001);
        decEn = 1'b0;
        #1;
        check("dec_x_off", {8'h00, Xreg}, 16'h0000);
        check("dec_y_off", {8'h00, Yreg}, 16'h0000);
        decEn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            IRx = 3'(i); IRy = 3'(7 - i);
            #1;
            check("dec_x_sweep", {8'h00, Xreg}, 16'h0001 << i);
            check("dec_y_sweep", {8'h00, Yreg}, 16'h0001 << (7 - i));
        end

        DIN = 16'hAAAA; dinOut = 1'b1; regOut = 8'b0000_1000;
        #1;
        check("mux_din_first", BusWires, 16'hAAAA);
        dinOut = 1'b0;
        #1;
        check("mux_r3", BusWires, 16'h1234);
        regOut = 8'b1000_0001;
        #1;
        check("mux_r0_over_r7", BusWires, 16'h1000);
        regOut = 8'b1000_0000; gOut = 1'b1;
        #1;
        check("mux_r7_over_g", BusWires, 16'h1007);
        regOut = 8'h00; gOut = 1'b0;
        #1;
        check("mux_none", BusWires, 16'h0000);

        g_op("add_wrap", 16'hFFFF, 16'h0002, 3'b000, 16'h0001);
        g_op("sub_wrap", 16'h0000, 16'h0001, 3'b001, 16'hFFFF);
        g_op("or",       16'hF0F0, 16'h0F0F, 3'b010, 16'hFFFF);
        g_op("slt_neg",  16'h8000, 16'h0001, 3'b011, 16'h0001);
        g_op("slt_swap", 16'h0001, 16'h8000, 3'b011, 16'h0000);
        g_op("sll4",     16'h8001, 16'h0004, 3'b100, 16'h0010);
        g_op("srl4",     16'h8001, 16'h0004, 3'b101, 16'h0800);
        g_op("sll_b13",  16'h8001, 16'h0013, 3'b100, 16'h0008);
        g_op("op110",    16'h1234, 16'h0001, 3'b110, 16'h0000);
        g_op("op111",    16'h1234, 16'h0001, 3'b111, 16'h0000);

        g_op("load_1234", 16'h1230, 16'h0004, 3'b000, 16'h1234);
        @(negedge Clock);
        Resetn = 1'b1; gIn = 1'b1; A = 16'h0005; DIN = 16'h0001; sinal_ULA = 3'b000;
        sb.push_back(16'h0000);
        @(posedge Clock);
        #1;
        Resetn = 1'b0; gIn = 1'b0;
        check_g("reset_over_gin");

        g_op("reload_1234", 16'h1230, 16'h0004, 3'b000, 16'h1234);
        A = 16'hFFFF; DIN = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            check("hold", G, 16'h1234);
        end

        @(negedge Clock);
        dinOut = 1'b0; gOut = 1'b1; A = 16'h0001; sinal_ULA = 3'b000;
        #1;
        check("bus_old_g", BusWires, 16'h1234);
        gIn = 1'b1;
        sb.push_back(16'h1235);
        @(posedge Clock);
        #1;
        check_g("gin_gout_1");
        check("bus_new_g", BusWires, 16'h1235);
        sb.push_back(16'h1236);
        @(posedge Clock);
        #1;
        gIn = 1'b0;
        check_g("gin_gout_2");

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
